// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter: data side wins by default, instruction side
// is forced through after STARVE_LIMIT consecutive data grants while it waits.
module sram_like_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        addr_ok,
    input  logic        data_ok
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        any_req, starve, sel, cur;
    logic        aok, dok;

    always_comb begin
        any_req = inst_req | data_req;
        starve  = inst_req && (cnt_q >= 4'(STARVE_LIMIT));
        sel     = data_req && !starve;
        cur     = (state_q == IDLE) ? sel : owner_q;
    end

    assign wr    = cur ? data_wr    : inst_wr;
    assign size  = cur ? data_size  : inst_size;
    assign addr  = cur ? data_addr  : inst_addr;
    assign wdata = cur ? data_wdata : inst_wdata;

    assign inst_rdata = rdata;
    assign data_rdata = rdata;

    // data_ok only counts once the address phase has been accepted
    always_comb begin
        req = 1'b0;
        aok = 1'b0;
        dok = 1'b0;
        unique case (state_q)
            IDLE: begin
                req = any_req;
                aok = any_req & addr_ok;
                dok = any_req & addr_ok & data_ok;
            end
            ADDR: begin
                req = 1'b1;
                aok = addr_ok;
                dok = addr_ok & data_ok;
            end
            DATA: begin
                dok = data_ok;
            end
            default: ;
        endcase
    end

    assign inst_addr_ok = aok & ~cur;
    assign data_addr_ok = aok &  cur;
    assign inst_data_ok = dok & ~cur;
    assign data_data_ok = dok &  cur;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = sel;
                    if (sel && inst_req)
                        cnt_d = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
                    else
                        cnt_d = 4'd0;
                    if (!addr_ok)
                        state_d = ADDR;
                    else if (!data_ok)
                        state_d = DATA;
                end
            end
            ADDR: begin
                if (addr_ok)
                    state_d = data_ok ? IDLE : DATA;
            end
            DATA: begin
                if (data_ok)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: handshakes, priority, grant lock,
// starvation guard, single-cycle transactions and reset mid-transaction.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        addr_ok, data_ok;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] IA = 32'hBFC0_0000;
    localparam logic [31:0] DA = 32'h8000_1000;

    always #5 clk = ~clk;

    sram_like_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok)
    );

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'b10;
        inst_addr = IA; inst_wdata = 32'h1111_1111;
        data_req = 0; data_wr = 0; data_size = 2'b10;
        data_addr = DA; data_wdata = 32'h2222_2222;
        rdata = 32'h0; addr_ok = 0; data_ok = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        @(negedge clk);
        checks++;
        if ({req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outs got %b want 00000",
                {req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        end
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_inst_read();
        inst_req = 1; addr_ok = 1;
        @(negedge clk);
        checks++;
        if ({req, addr, inst_addr_ok, data_addr_ok} !== {1'b1, IA, 2'b10}) begin
            errors++;
            $display("FAIL inst_rd_c0 got req=%b addr=%h iok=%b dok=%b",
                req, addr, inst_addr_ok, data_addr_ok);
        end
        tick();
        inst_req = 0; addr_ok = 0;
        @(negedge clk);
        checks++;
        if ({req, inst_data_ok, data_data_ok} !== 3'b000) begin
            errors++;
            $display("FAIL inst_rd_c1 got req=%b idok=%b ddok=%b",
                req, inst_data_ok, data_data_ok);
        end
        tick();
        data_ok = 1; rdata = 32'h3C1D_0000;
        @(negedge clk);
        checks++;
        if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !==
            {2'b10, 32'h3C1D_0000, 32'h3C1D_0000}) begin
            errors++;
            $display("FAIL inst_rd_c2 got idok=%b ddok=%b rd=%h", inst_data_ok,
                data_data_ok, inst_rdata);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_conflict();
        inst_req = 1; data_req = 1; addr_ok = 1;
        @(negedge clk);
        checks++;
        if ({req, addr, data_addr_ok, inst_addr_ok} !== {1'b1, DA, 2'b10}) begin
            errors++;
            $display("FAIL conflict_grant got addr=%h dok=%b iok=%b",
                addr, data_addr_ok, inst_addr_ok);
        end
        tick();
        data_req = 0; addr_ok = 0; data_ok = 1;
        @(negedge clk);
        checks++;
        if ({req, data_data_ok, inst_data_ok, inst_addr_ok} !== 4'b0100) begin
            errors++;
            $display("FAIL conflict_data got req=%b ddok=%b idok=%b iaok=%b",
                req, data_data_ok, inst_data_ok, inst_addr_ok);
        end
        tick();
        addr_ok = 1; data_ok = 1;
        @(negedge clk);
        checks++;
        if ({addr, inst_addr_ok, inst_data_ok, data_addr_ok} !== {IA, 3'b110}) begin
            errors++;
            $display("FAIL conflict_inst got addr=%h iaok=%b idok=%b daok=%b",
                addr, inst_addr_ok, inst_data_ok, data_addr_ok);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_grant_lock();
        inst_req = 1;
        @(negedge clk);
        checks++;
        if ({req, addr, inst_addr_ok} !== {1'b1, IA, 1'b0}) begin
            errors++;
            $display("FAIL lock_c0 got req=%b addr=%h iaok=%b", req, addr, inst_addr_ok);
        end
        tick();
        data_req = 1;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({req, addr, data_addr_ok} !== {1'b1, IA, 1'b0}) begin
                errors++;
                $display("FAIL lock_hold%0d got addr=%h daok=%b", i, addr, data_addr_ok);
            end
            tick();
        end
        addr_ok = 1;
        @(negedge clk);
        checks++;
        if ({addr, inst_addr_ok, data_addr_ok} !== {IA, 2'b10}) begin
            errors++;
            $display("FAIL lock_aok got addr=%h iaok=%b daok=%b",
                addr, inst_addr_ok, data_addr_ok);
        end
        tick();
        inst_req = 0; addr_ok = 0; data_ok = 1;
        @(negedge clk);
        checks++;
        if ({req, inst_data_ok, data_data_ok, data_addr_ok} !== 4'b0100) begin
            errors++;
            $display("FAIL lock_dok got req=%b idok=%b ddok=%b daok=%b",
                req, inst_data_ok, data_data_ok, data_addr_ok);
        end
        tick();
        addr_ok = 1; data_ok = 1;
        @(negedge clk);
        checks++;
        if ({addr, data_addr_ok, data_data_ok} !== {DA, 2'b11}) begin
            errors++;
            $display("FAIL lock_next got addr=%h daok=%b ddok=%b",
                addr, data_addr_ok, data_data_ok);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic [5:0] exp_data;
        exp_data = 6'b101111;
        inst_req = 1; data_req = 1; addr_ok = 1; data_ok = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({data_addr_ok, inst_addr_ok, addr} !==
                {exp_data[i], ~exp_data[i], exp_data[i] ? DA : IA}) begin
                errors++;
                $display("FAIL starve_g%0d got daok=%b iaok=%b addr=%h want data=%b",
                    i, data_addr_ok, inst_addr_ok, addr, exp_data[i]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_same_cycle_write();
        data_req = 1; data_wr = 1; data_size = 2'b10; data_wdata = 32'hDEAD_BEEF;
        addr_ok = 1; data_ok = 1;
        @(negedge clk);
        checks++;
        if ({req, wr, size, wdata, data_addr_ok, data_data_ok} !==
            {1'b1, 1'b1, 2'b10, 32'hDEAD_BEEF, 2'b11}) begin
            errors++;
            $display("FAIL wr1c got req=%b wr=%b size=%b wdata=%h daok=%b ddok=%b",
                req, wr, size, wdata, data_addr_ok, data_data_ok);
        end
        tick();
        data_req = 0; data_wr = 0; inst_req = 1; data_ok = 0;
        @(negedge clk);
        checks++;
        if ({req, addr, inst_addr_ok} !== {1'b1, IA, 1'b1}) begin
            errors++;
            $display("FAIL wr1c_next got req=%b addr=%h iaok=%b", req, addr, inst_addr_ok);
        end
        tick();
        inst_req = 0; addr_ok = 0; data_ok = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid_data();
        data_req = 1; addr_ok = 1;
        tick();
        data_req = 0; addr_ok = 0;
        @(negedge clk);
        checks++;
        if ({req, data_data_ok} !== 2'b00) begin
            errors++;
            $display("FAIL rst_pre got req=%b ddok=%b", req, data_data_ok);
        end
        tick();
        inst_req = 1;
        #2 rst = 0;
        #1;
        checks++;
        if ({req, addr, inst_addr_ok} !== {1'b1, IA, 1'b0}) begin
            errors++;
            $display("FAIL rst_async got req=%b addr=%h iaok=%b", req, addr, inst_addr_ok);
        end
        inst_req = 0;
        @(negedge clk);
        checks++;
        if (req !== 1'b0) begin
            errors++;
            $display("FAIL rst_req got %b want 0", req);
        end
        tick();
        rst = 1;
        data_ok = 1; rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++;
        if ({inst_data_ok, data_data_ok, req, data_rdata} !==
            {3'b000, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL rst_drop got idok=%b ddok=%b req=%b rd=%h",
                inst_data_ok, data_data_ok, req, data_rdata);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_inst_read();
        test_conflict();
        test_grant_lock();
        test_starvation();
        test_same_cycle_write();
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
